// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream_gen / stream_check pair.
package stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    RUN
  } chk_state_t;

  // Covers tkeep up to 64 bits; users truncate to their own width.
  localparam logic [63:0] KEEP_ALL = '1;

  function automatic logic [63:0] sat_inc(input logic [63:0] value, input logic [63:0] max);
    return (value >= max) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/stream_check_if.sv
// AXI4-Stream beat bundle; master drives data/valid, slave drives ready.
interface stream_check_if #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = DATA_W / 8
) ();

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (
    output tdata, tkeep, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tlast, tvalid,
    output tready
  );

endinterface

// File: rtl/stream_rate_gen.sv
// One-in-(data_rate+1) strobe; strobe_nxt is the combinational look-ahead of the
// next counter value so callers can register a ready/valid aligned to it.
module stream_rate_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] data_rate,
  output logic        strobe_nxt
);

  logic [15:0] rate_cnt;
  logic [15:0] rate_cnt_nxt;

  // Compare with >= so lowering data_rate mid-run wraps immediately.
  always_comb begin
    rate_cnt_nxt = rate_cnt;
    if (run) begin
      rate_cnt_nxt = (rate_cnt >= data_rate) ? 16'd0 : rate_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rate_cnt <= 16'd0;
    end else begin
      rate_cnt <= rate_cnt_nxt;
    end
  end

  assign strobe_nxt = (rate_cnt_nxt == 16'd0);

endmodule

// File: rtl/stream_check.sv
// AXI4-Stream sink that throttles tready and checks stream_gen counter frames.
// Counters/error update one edge after the accepted beat; tready is registered.
module stream_check
  import stream_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int KEEP_W = DATA_W / 8,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [31:0]      frame_size,
  input  logic [15:0]      data_rate,
  stream_check_if.slave    axis,
  output logic             synced,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] beat_count,
  output logic [CNT_W-1:0] data_err_count,
  output logic [CNT_W-1:0] len_err_count,
  output logic [CNT_W-1:0] keep_err_count,
  output logic             error
);

  chk_state_t        state;
  logic              tready_q;
  logic              strobe_nxt;
  logic [DATA_W-1:0] expected;
  logic [31:0]       beat_idx;
  logic              acc;
  logic              run_beat;
  logic              data_bad;
  logic              keep_bad;
  logic              len_bad;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] value);
    return CNT_W'(sat_inc(64'(value), 64'({CNT_W{1'b1}})));
  endfunction

  stream_rate_gen u_rate (
    .clk        (clk),
    .reset      (reset),
    .run        (state != IDLE),
    .data_rate  (data_rate),
    .strobe_nxt (strobe_nxt)
  );

  assign axis.tready = tready_q;
  assign acc         = axis.tvalid & tready_q;
  assign run_beat    = acc && (state == RUN);
  assign data_bad    = run_beat && (axis.tdata != expected);
  assign keep_bad    = run_beat && (axis.tkeep != KEEP_W'(KEEP_ALL));
  assign len_bad     = run_beat && axis.tlast && (beat_idx != frame_size);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      tready_q       <= 1'b0;
      synced         <= 1'b0;
      error          <= 1'b0;
      expected       <= '0;
      beat_idx       <= '0;
      frame_count    <= '0;
      beat_count     <= '0;
      data_err_count <= '0;
      len_err_count  <= '0;
      keep_err_count <= '0;
    end else begin
      // Next state is non-IDLE exactly when enable is high.
      tready_q <= strobe_nxt & enable;

      case (state)
        IDLE: begin
          if (enable) state <= SYNC;
        end
        SYNC: begin
          if (acc && axis.tlast) begin
            expected <= axis.tdata + 1'b1;
            beat_idx <= '0;
            synced   <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (acc) begin
            // Matches expected+1 on good data and resyncs on bad data.
            expected   <= axis.tdata + 1'b1;
            beat_idx   <= axis.tlast ? 32'd0 : 32'(sat_inc(64'(beat_idx), 64'hFFFF_FFFF));
            beat_count <= cnt_inc(beat_count);
            if (axis.tlast) frame_count    <= cnt_inc(frame_count);
            if (data_bad)   data_err_count <= cnt_inc(data_err_count);
            if (keep_bad)   keep_err_count <= cnt_inc(keep_err_count);
            if (len_bad)    len_err_count  <= cnt_inc(len_err_count);
            if (data_bad || keep_bad || len_bad) error <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (!enable) begin
        state  <= IDLE;
        synced <= 1'b0;
      end

      if (clear) begin
        frame_count    <= '0;
        beat_count     <= '0;
        data_err_count <= '0;
        len_err_count  <= '0;
        keep_err_count <= '0;
        error          <= 1'b0;
      end
    end
  end

endmodule

// File: doc/stream_check.md
Name: stream_check

Overview:
- Counterpart to stream_gen: the AXI4-Stream sink for the host-to-card (stream_out) DMA direction.
- Throttles tready to a programmable duty cycle and checks incoming frames against the stream_gen pattern:
  - incrementing 32-bit counter data
  - full tkeep
  - fixed frame length terminated by tlast
- Status counters are exported to the system block for PS readback and bring-up debug.

Parameters:
- DATA_W, 32, tdata width in bits.
- KEEP_W, DATA_W/8, tkeep width.
- CNT_W, 32, width of all status counters.

Ports:
- clk  input  1  stream clock (axi_aclk domain)
- reset  input  1  synchronous, active-high reset
- enable  input  1  checker run enable, level
- clear  input  1  one-cycle pulse; zeroes all counters and the sticky error flag
- frame_size  input  32  expected beats per frame minus 1 (0x7FF = 2048 beats)
- data_rate  input  16  tready asserted 1 cycle in every data_rate+1; 0 = always ready
- tdata  input  DATA_W  stream data
- tkeep  input  KEEP_W  byte enables
- tlast  input  1  end of frame
- tvalid  input  1  source valid
- tready  output  1  sink ready, registered
- synced  output  1  high once the first frame boundary has been seen
- frame_count  output  CNT_W  frames completed (tlast beats accepted in RUN)
- beat_count  output  CNT_W  beats accepted in RUN
- data_err_count  output  CNT_W  beats whose tdata differs from expected
- len_err_count  output  CNT_W  frames whose length differs from frame_size+1
- keep_err_count  output  CNT_W  beats with tkeep not all ones
- error  output  1  sticky OR of all error events

Behaviour:
- Reset values:
  - tready=0, synced=0, error=0
  - all counters 0
  - rate_cnt=0, expected=0, beat_idx=0
  - state=IDLE
- Accept condition: acc = tvalid & tready. All checks act only on acc cycles.
- Ready throttle:
  - rate_cnt increments every cycle while state != IDLE.
  - It wraps to 0 when rate_cnt >= data_rate; this also covers data_rate lowered mid-run.
  - tready is registered: next tready = (next rate_cnt == 0) & (next state != IDLE).
  - data_rate=0 gives continuous tready. data_rate=3 gives tready on 1 cycle in 4.
- State machine:
  - IDLE:
    - tready=0.
    - enable=1 moves to SYNC next cycle.
  - SYNC:
    - Accepted beats are discarded and not counted.
    - On acc & tlast: expected <= tdata+1, beat_idx <= 0, synced <= 1, move to RUN.
  - RUN: per acc beat:
    - Data check: tdata != expected increments data_err_count, then expected <= tdata+1 (resync, so one bad word gives one error). Otherwise expected <= expected+1. Arithmetic is modulo 2^DATA_W, so 0xFFFFFFFF is followed by 0x00000000 without error.
    - Keep check: tkeep != all-ones increments keep_err_count.
    - Length check on tlast: len_err_count increments if beat_idx != frame_size; then beat_idx <= 0 and frame_count increments.
    - Without tlast: beat_idx increments, saturating at all-ones. An over-long frame is counted once, at its eventual tlast.
    - beat_count increments on every acc.
  - Any state with enable=0: go to IDLE next cycle, tready=0 next cycle, synced <= 0. Counters hold. A beat accepted in the same cycle enable falls is still checked.
  - Re-enable always re-enters SYNC.
- Counters:
  - All counters saturate at all-ones; they never wrap.
  - Multiple error types on one beat each increment their own counter.
- clear:
  - Zeroes all counters and error in the next cycle.
  - Has priority over a same-cycle increment; that beat's event is lost.
  - Does not affect state, expected or synced.
- error sets on any data, keep or length error event and holds until clear or reset.
- reset mid-frame returns to IDLE; the partial frame is dropped and the source must tolerate tready=0.
- Latency: counters and error reflect an accepted beat on the following clock edge.

Decomposition:
- Package stream_pkg:
  - state enum chk_state_t {IDLE, SYNC, RUN}
  - localparam KEEP_ALL
  - saturating-increment function sat_inc shared with future stream blocks
- Sub-module stream_rate_gen: data_rate counter producing the one-in-N strobe, reusable by stream_gen.

Test Plan:
- data_rate=0, frame_size=7: 4 frames of counter data 0..31 with tlast every 8th beat. The first frame syncs only, so frame_count=3, beat_count=24, all error counts 0, tready continuously high after SYNC.
- data_rate=3 with constant tvalid: tready is high exactly 1 cycle in 4. Over 64 cycles, 16 beats are accepted and data remains continuous.
- Word 0x10 replaced by 0x99 mid-frame: data_err_count=1, and the following 0x9A is accepted with no further error.
- Frames of 7 and 9 beats with frame_size=7: len_err_count=2, frame_count increments for each frame.
- Beat with tkeep=4'h7 and wrong data on the same beat: keep_err_count=1, data_err_count=1, error=1. A clear pulse zeroes the counters and error, and a later clean frame leaves error=0.
- enable dropped mid-frame, then restored: tready=0 the next cycle, synced=0, counters hold. After the next tlast synced=1 and checking resumes with no spurious errors.
